// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: decodes the header address,
// steps router_register through its load phases and drives FIFO write enable / busy.
module router_fsm #(
    parameter int unsigned NUM_DEST = 3,
    parameter int unsigned ADDR_W   = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                pkt_valid,
    input  logic [ADDR_W-1:0]   data_in,
    input  logic                fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_reset,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                detect_addr,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                full_state,
    output logic                laf_state,
    output logic                rst_int_reg,
    output logic                write_enb_reg,
    output logic                busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;

    logic                addr_ok;
    logic                empty_hdr;
    logic                empty_sel;
    logic                srst_sel;

    // Out-of-range indices read as 0, so an address >= NUM_DEST never selects a FIFO.
    function automatic logic bit_at(input logic [NUM_DEST-1:0] vec,
                                    input logic [ADDR_W-1:0]   idx);
        logic b;
        b = 1'b0;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            if (ADDR_W'(i) == idx) begin
                b = vec[i];
            end
        end
        return b;
    endfunction

    assign addr_ok   = (32'(data_in) < NUM_DEST);
    assign empty_hdr = bit_at(fifo_empty, data_in);
    assign empty_sel = bit_at(fifo_empty, addr_q);
    assign srst_sel  = bit_at(soft_reset, addr_q);

    // Next-state and address-capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        unique case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    addr_d = data_in;
                    if (addr_ok) begin
                        state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                state_d = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_d = DECODE_ADDRESS;
            end
        endcase

        // A timeout on the selected destination abandons the packet from any active state.
        if (state_q != DECODE_ADDRESS && srst_sel) begin
            state_d = DECODE_ADDRESS;
        end
    end

    // State register; outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= DECODE_ADDRESS;
            addr_q        <= '0;
            detect_addr   <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            full_state    <= 1'b0;
            laf_state     <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            detect_addr   <= (state_d == DECODE_ADDRESS);
            lfd_state     <= (state_d == LOAD_FIRST_DATA);
            ld_state      <= (state_d == LOAD_DATA);
            full_state    <= (state_d == FIFO_FULL_STATE);
            laf_state     <= (state_d == LOAD_AFTER_FULL);
            rst_int_reg   <= (state_d == CHECK_PARITY_ERROR);
            write_enb_reg <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY)
                             || (state_d == LOAD_AFTER_FULL);
            busy          <= (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks each packet scenario and compares the
// packed output vector against hand-written per-state values.
module tb_router_fsm;

    localparam int unsigned NUM_DEST = 3;
    localparam int unsigned ADDR_W   = 2;

    // {detect, lfd, ld, full, laf, rst_int, write_enb, busy}
    localparam logic [7:0] S_DEC = 8'b1000_0000;
    localparam logic [7:0] S_WTE = 8'b0000_0001;
    localparam logic [7:0] S_LFD = 8'b0100_0001;
    localparam logic [7:0] S_LD  = 8'b0010_0010;
    localparam logic [7:0] S_FUL = 8'b0001_0001;
    localparam logic [7:0] S_LAF = 8'b0000_1011;
    localparam logic [7:0] S_LP  = 8'b0000_0011;
    localparam logic [7:0] S_CPE = 8'b0000_0101;

    logic                clk;
    logic                rstn;
    logic                pkt_valid;
    logic [ADDR_W-1:0]   data_in;
    logic                fifo_full;
    logic [NUM_DEST-1:0] fifo_empty;
    logic [NUM_DEST-1:0] soft_reset;
    logic                parity_done;
    logic                low_pkt_valid;
    logic                detect_addr;
    logic                lfd_state;
    logic                ld_state;
    logic                full_state;
    logic                laf_state;
    logic                rst_int_reg;
    logic                write_enb_reg;
    logic                busy;

    int n_checks;
    int n_fail;
    int we_cycles;
    int ri_cycles;

    router_fsm #(.NUM_DEST(NUM_DEST), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_addr   (detect_addr),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .full_state    (full_state),
        .laf_state     (laf_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {detect_addr, lfd_state, ld_state, full_state,
                laf_state, rst_int_reg, write_enb_reg, busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait for the next falling edge and compare the output vector there.
    task automatic expect_state(input string tag, input logic [7:0] exp);
        @(negedge clk);
        if (write_enb_reg) we_cycles++;
        if (rst_int_reg) ri_cycles++;
        check(tag, outs(), exp);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; we_cycles = 0; ri_cycles = 0;
        rstn = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
        fifo_empty = '0; soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;

        expect_state("reset", S_DEC);
        rstn = 1'b1;

        // Normal packet to destination 2
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b100;
        we_cycles = 0; ri_cycles = 0;
        expect_state("norm_lfd", S_LFD);
        data_in = 2'd0;
        for (int i = 0; i < 5; i++) expect_state("norm_ld", S_LD);
        pkt_valid = 1'b0;
        expect_state("norm_lp", S_LP);
        expect_state("norm_cpe", S_CPE);
        expect_state("norm_dec", S_DEC);
        check("norm_we_cycles", 8'(we_cycles), 8'd6);
        check("norm_ri_cycles", 8'(ri_cycles), 8'd1);

        // Busy destination 1, empty rises after 4 wait cycles
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b000;
        for (int i = 0; i < 4; i++) expect_state("wait_busy", S_WTE);
        fifo_empty = 3'b010;
        expect_state("wait_lfd", S_LFD);
        expect_state("wait_ld", S_LD);

        // Full stall, LAF resumes LOAD_DATA
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) expect_state("full_hold", S_FUL);
        fifo_full = 1'b0;
        expect_state("laf", S_LAF);
        expect_state("laf_to_ld", S_LD);

        // Full wins over pkt_valid falling; LAF then goes to parity via low_pkt_valid
        fifo_full = 1'b1; pkt_valid = 1'b0;
        expect_state("full_prio", S_FUL);
        fifo_full = 1'b0;
        expect_state("laf2", S_LAF);
        low_pkt_valid = 1'b1;
        expect_state("laf_to_lp", S_LP);
        low_pkt_valid = 1'b0;
        expect_state("lp_cpe", S_CPE);
        fifo_full = 1'b1;
        expect_state("cpe_to_full", S_FUL);
        fifo_full = 1'b0;
        expect_state("laf3", S_LAF);
        parity_done = 1'b1;
        expect_state("laf_to_dec", S_DEC);
        parity_done = 1'b0;

        // Soft reset: non-selected ignored, selected aborts
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b100;
        expect_state("sr_lfd", S_LFD);
        expect_state("sr_ld", S_LD);
        data_in = 2'd0; soft_reset = 3'b001;
        expect_state("sr_other", S_LD);
        soft_reset = 3'b100;
        expect_state("sr_sel", S_DEC);
        soft_reset = 3'b000; pkt_valid = 1'b0;
        expect_state("sr_idle", S_DEC);

        // Invalid address stays in DECODE
        pkt_valid = 1'b1; data_in = 2'd3; fifo_empty = 3'b111;
        for (int i = 0; i < 3; i++) expect_state("bad_addr", S_DEC);

        // Async reset mid-LOAD_DATA
        data_in = 2'd0; fifo_empty = 3'b001;
        expect_state("ar_lfd", S_LFD);
        expect_state("ar_ld", S_LD);
        #2 rstn = 1'b0;
        #1 check("async_rst", outs(), S_DEC);
        pkt_valid = 1'b0;
        @(negedge clk);
        check("rst_hold", outs(), S_DEC);
        rstn = 1'b1;
        expect_state("post_rst", S_DEC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
